if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the dual-issue MIPS pipeline. Sits directly upstream of the ID stage's instruction FIFO.
- Owns the PC and issues one 64-bit fetch per cycle, covering PC and PC+4, to inst_sram.
- Tags each fetch with {discard, ce, pc} on if_to_id_bus.
- Absorbs branch redirects (br_bus) and exception redirects (flush/new_pc), deferring them while the PC is stalled.

---
 rtl/if_fetch_stage_pkg.sv | 31 +++
 rtl/if_fetch_stage_if.sv | 37 +++
 rtl/if_fetch_stage_pc_redirect_unit.sv | 99 +++++++++
 rtl/if_fetch_stage.sv | 80 ++++++++
 tb/tb_if_fetch_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage_pkg
// Purpose  : Shared types and constants for the instruction-fetch stage:
//            stall vector type, stall encodings, bus widths, reset PC and
//            fetch-redirect state encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_stage_pkg;

    localparam int STALL_WD    = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 34;

    typedef logic [STALL_WD-1:0] StallBus;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [31:0] RESET_PC_DEFAULT     = 32'hBFC0_0000;
    localparam logic [31:0] FETCH_STRIDE_DEFAULT = 32'd8;

    // Redirect-tracking state encodings
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t S_BOOT = 2'd0;
    localparam fetch_state_t S_RUN  = 2'd1;
    localparam fetch_state_t S_HOLD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage_if
// Purpose  : Bundles the fetch stage's control inputs (stall, flush, branch)
//            and its outputs (IF->ID bus, inst_sram request, address error).
// Modports : master - the fetch stage (drives sram request and IF->ID bus)
//            slave  - the surrounding pipeline / memory side
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    StallBus                stall;
    logic                   flush;
    logic [31:0]            new_pc;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic                   fetch_adel;

    modport master (
        input  stall, flush, new_pc, br_bus,
        output if_to_id_bus, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata, fetch_adel
    );

    modport slave (
        output stall, flush, new_pc, br_bus,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata, fetch_adel
    );

endinterface
`default_nettype wire

// File: rtl/if_fetch_stage_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_unit
// Purpose  : Next-PC priority mux (flush > branch > pending > sequential)
//            and the pending-redirect tracker that defers a redirect seen
//            while the PC is stalled.
// Ports    : clk, rst          - clock, async active-high reset
//            stop              - PC stall request
//            flush, new_pc     - exception redirect
//            br_e, br_addr     - taken branch redirect
//            pc_reg            - current PC
//            next_pc           - PC to load on pc_load
//            pc_load           - load next_pc into the PC (and enable fetch)
//            hold              - a deferred redirect is pending
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_unit
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [31:0] FETCH_STRIDE = FETCH_STRIDE_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stop,
    input  wire logic        flush,
    input  wire logic [31:0] new_pc,
    input  wire logic        br_e,
    input  wire logic [31:0] br_addr,
    input  wire logic [31:0] pc_reg,
    output logic      [31:0] next_pc,
    output logic             pc_load,
    output logic             hold
);

    fetch_state_t r_state;
    fetch_state_t w_state_nx;
    logic [31:0]  r_pend_pc;
    logic [31:0]  w_pend_nx;
    logic         w_redirect;
    logic [31:0]  w_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_BOOT;
            r_pend_pc <= 32'd0;
        end else begin
            r_state   <= w_state_nx;
            r_pend_pc <= w_pend_nx;
        end
    end

    always_comb begin
        w_redirect = flush | br_e;
        w_target   = flush ? new_pc : br_addr;
        w_state_nx = r_state;
        w_pend_nx  = r_pend_pc;
        pc_load    = 1'b0;
        next_pc    = pc_reg + FETCH_STRIDE;

        case (r_state)
            S_BOOT: begin
                // No valid fetch yet, so a branch cannot apply; only flush
                // can override the boot address.
                next_pc = flush ? new_pc : RESET_PC;
                if (!stop) begin
                    pc_load    = 1'b1;
                    w_state_nx = S_RUN;
                end else if (flush) begin
                    w_pend_nx  = new_pc;
                    w_state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                // A fresh redirect supersedes the one already pending.
                next_pc = w_redirect ? w_target : r_pend_pc;
                if (!stop) begin
                    pc_load    = 1'b1;
                    w_state_nx = S_RUN;
                end else if (w_redirect) begin
                    w_pend_nx  = w_target;
                end
            end
            default: begin
                next_pc = w_redirect ? w_target : (pc_reg + FETCH_STRIDE);
                if (!stop) begin
                    pc_load    = 1'b1;
                end else if (w_redirect) begin
                    w_pend_nx  = w_target;
                    w_state_nx = S_HOLD;
                end
            end
        endcase

        hold = (r_state == S_HOLD);
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction-fetch stage of the dual-issue pipeline. Owns the PC,
//            issues one 64-bit fetch (PC, PC+4) per cycle to inst_sram and
//            tags it {discard, ce, pc} for the ID stage.
// Ports    : clk     - clock
//            rst     - asynchronous active-high reset
//            bus_if  - if_fetch_stage_if.master: stall, flush/new_pc,
//                      br_bus in; if_to_id_bus, inst_sram_*, fetch_adel out
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [31:0] FETCH_STRIDE = FETCH_STRIDE_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    if_fetch_stage_if.master  bus_if
);

    logic [31:0] r_pc;
    logic        r_ce;
    logic        w_stop;
    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic [31:0] w_next_pc;
    logic        w_pc_load;
    logic        w_hold;
    logic        w_discard;
    logic        w_unused_stall;

    assign w_stop         = (bus_if.stall[0] == Stop);
    assign w_br_e         = bus_if.br_bus[BR_WD-1];
    assign w_br_addr      = bus_if.br_bus[31:0];
    // Only stall[0] concerns this stage; the rest belongs to later stages.
    assign w_unused_stall = &{1'b0, bus_if.stall[STALL_WD-1:1]};

    pc_redirect_unit #(
        .RESET_PC     (RESET_PC),
        .FETCH_STRIDE (FETCH_STRIDE)
    ) u_redirect (
        .clk     (clk),
        .rst     (rst),
        .stop    (w_stop),
        .flush   (bus_if.flush),
        .new_pc  (bus_if.new_pc),
        .br_e    (w_br_e),
        .br_addr (w_br_addr),
        .pc_reg  (r_pc),
        .next_pc (w_next_pc),
        .pc_load (w_pc_load),
        .hold    (w_hold)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= 32'd0;
            r_ce <= 1'b0;
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
        end
    end

    // Combinational so the fetch ID captures on a redirect edge (or while a
    // redirect is pending) is already marked stale.
    assign w_discard = r_ce & (bus_if.flush | w_br_e | w_hold);

    assign bus_if.if_to_id_bus    = {w_discard, r_ce, r_pc};
    assign bus_if.inst_sram_en    = r_ce;
    assign bus_if.inst_sram_wen   = 4'b0000;
    assign bus_if.inst_sram_addr  = r_pc;
    assign bus_if.inst_sram_wdata = 32'd0;
    assign bus_if.fetch_adel      = r_ce & (r_pc[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Self-checking bench for if_fetch_stage: directed scenarios then
//            randomized stall/flush/branch/reset traffic against a
//            behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam logic [31:0] C_RST_PC = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_stage_if u_if ();

    if_fetch_stage #(
        .RESET_PC     (C_RST_PC),
        .FETCH_STRIDE (32'd8)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (u_if.master)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: PC, fetch-valid, "has started", pending redirect.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_ce;
    bit          m_started;
    bit          m_pend_v;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_pend = 32'd0; m_ce = 0; m_started = 0; m_pend_v = 0;
    endtask

    task automatic check_model();
        logic disc;
        disc = m_ce & (u_if.flush | u_if.br_bus[32] | m_pend_v);
        chk("bus",  {2'b0, u_if.if_to_id_bus}, {2'b0, disc, m_ce, m_pc});
        chk("en",   {35'b0, u_if.inst_sram_en}, {35'b0, m_ce});
        chk("addr", {4'b0, u_if.inst_sram_addr}, {4'b0, m_pc});
        chk("adel", {35'b0, u_if.fetch_adel}, {35'b0, m_ce & (m_pc[1:0] != 2'b00)});
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit          stop, f, be;
        logic [31:0] na, ba, want;
        stop = u_if.stall[0]; f = u_if.flush; na = u_if.new_pc;
        be = u_if.br_bus[32]; ba = u_if.br_bus[31:0];
        if (!m_started) begin
            if (!stop) begin
                m_pc = f ? na : C_RST_PC; m_ce = 1; m_started = 1;
            end else if (f) begin
                m_pend = na; m_pend_v = 1; m_started = 1;
            end
        end else begin
            want = f ? na : be ? ba : m_pend_v ? m_pend : m_pc + 32'd8;
            if (!stop) begin
                m_pc = want; m_ce = 1; m_pend_v = 0;
            end else if (f | be) begin
                m_pend = f ? na : ba; m_pend_v = 1;
            end
        end
    endtask

    task automatic drive(input bit st, input bit f, input logic [31:0] na,
                         input bit be, input logic [31:0] ba);
        @(negedge clk);
        rst = 1'b0;
        u_if.stall = '0;
        u_if.stall[0] = st;
        u_if.flush = f;
        u_if.new_pc = na;
        u_if.br_bus = {be, ba};
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle();
        drive(0, 0, 32'd0, 0, 32'd0);
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] pc,
                                input bit disc, input bit adel);
        chk(tag, {2'b0, u_if.if_to_id_bus}, {2'b0, disc, 1'b1, pc});
        chk({tag, "_adel"}, {35'b0, u_if.fetch_adel}, {35'b0, adel});
    endtask

    // Assert rst mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_bus",  {2'b0, u_if.if_to_id_bus}, 36'd0);
        chk("rst_en",   {35'b0, u_if.inst_sram_en}, 36'd0);
        chk("rst_addr", {4'b0, u_if.inst_sram_addr}, 36'd0);
        chk("rst_adel", {35'b0, u_if.fetch_adel}, 36'd0);
        chk("rst_wr",   {u_if.inst_sram_wen, u_if.inst_sram_wdata}, 36'd0);
        @(posedge clk);
    endtask

    initial begin
        u_if.stall = '0; u_if.flush = 0; u_if.new_pc = '0; u_if.br_bus = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Sequential fetch after reset
        idle(); tick();
        idle(); expect_fetch("seq0", 32'hBFC0_0000, 0, 0); tick();
        idle(); expect_fetch("seq1", 32'hBFC0_0008, 0, 0); tick();
        // Unstalled branch
        drive(0, 0, 32'd0, 1, 32'hBFC0_0100); expect_fetch("br_cyc", 32'hBFC0_0010, 1, 0); tick();
        idle(); expect_fetch("br_tgt", 32'hBFC0_0100, 0, 0); tick();
        // Branch during a 3-cycle stall is deferred
        drive(1, 0, 32'd0, 1, 32'hBFC0_0200); expect_fetch("stl_br", 32'hBFC0_0108, 1, 0); tick();
        drive(1, 0, 32'd0, 0, 32'd0); expect_fetch("stl_h1", 32'hBFC0_0108, 1, 0); tick();
        drive(1, 0, 32'd0, 0, 32'd0); expect_fetch("stl_h2", 32'hBFC0_0108, 1, 0); tick();
        idle(); expect_fetch("stl_rel", 32'hBFC0_0108, 1, 0); tick();
        // Flush beats a simultaneous branch
        drive(0, 1, 32'hBFC0_0380, 1, 32'hBFC0_0040); expect_fetch("pend_tgt", 32'hBFC0_0200, 1, 0); tick();
        idle(); expect_fetch("flush_win", 32'hBFC0_0380, 0, 0); tick();
        // Flush while holding a deferred branch overrides it
        drive(1, 0, 32'd0, 1, 32'hBFC0_0200); expect_fetch("h_br", 32'hBFC0_0388, 1, 0); tick();
        drive(1, 1, 32'hBFC0_0380, 0, 32'd0); expect_fetch("h_fl", 32'hBFC0_0388, 1, 0); tick();
        idle(); tick();
        idle(); expect_fetch("h_flush", 32'hBFC0_0380, 0, 0); tick();
        // Misaligned target raises address error, PC advances normally
        drive(0, 0, 32'd0, 1, 32'hBFC0_0102); tick();
        idle(); expect_fetch("adel0", 32'hBFC0_0102, 0, 1); tick();
        drive(1, 0, 32'd0, 1, 32'hBFC0_0200); expect_fetch("adel1", 32'hBFC0_010A, 1, 1); tick();
        drive(1, 0, 32'd0, 0, 32'd0); tick();
        // Reset while a redirect is pending discards it
        do_reset();
        idle(); tick();
        idle(); expect_fetch("restart", 32'hBFC0_0000, 0, 0); tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] na, ba;
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                na = $urandom; ba = $urandom;
                if ($urandom_range(3) != 0) na[1:0] = 2'b00;
                if ($urandom_range(3) != 0) ba[1:0] = 2'b00;
                drive($urandom_range(9) < 3, $urandom_range(11) == 0, na,
                      $urandom_range(6) == 0, ba);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
